config_loader: RTL and testbench

Bitstream loader for the logic tile configuration chain. Accepts configuration words from a host port over a valid/ready handshake and serializes them one bit per cycle onto the chain's serial input. Owns the chain's shift enable and active-low chain reset. Sits between the FPGA's configuration interface and the first tile's `config_in`/`config_enable`/`config_nreset` pins; tiles are daisy-chained `config_out` to `config_in`.

---
 rtl/config_loader.sv | 159 +++++++++++++++
 tb/tb_config_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// config_loader
//
// Bitstream loader for the logic tile configuration chain. Host words arrive
// over a valid/ready handshake and are serialized LSB first, one bit per
// cycle, onto the chain's serial input. The loader owns the chain's shift
// enable and its active-low reset; a load runs IDLE -> CLEAR -> SHIFT -> DONE.
//
// Ports
//   clock, reset   : single clock (also clocks the chain), async active-high reset
//   start          : begin a load (sampled only in IDLE)
//   abort          : cancel the load in progress (priority over all transitions)
//   word_data      : host configuration word, LSB shifted first
//   word_valid     : word_data valid
//   word_ready     : loader accepts a word this cycle (combinational)
//   chain_data     : serial bit to the first tile's config_in
//   chain_enable   : chain shift enable
//   chain_nreset   : active-low chain reset, held low during CLEAR
//   busy           : load in progress
//   done           : one-cycle pulse when the final bit has been shifted
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 146,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  output logic                  chain_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_WORDS = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int BIT_W     = $clog2(CHAIN_LENGTH + 1);
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int BCNT_W    = $clog2(WORD_WIDTH + 1);
  localparam int CLR_W     = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CLR_W-1:0]      clear_cnt_q, clear_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d;
  logic [BCNT_W-1:0]     buf_count_q, buf_count_d;
  logic                  nreset_q, nreset_d;

  logic                  in_shift;
  logic [BIT_W-1:0]      bits_after;
  logic [BIT_W-1:0]      remaining;

  assign in_shift     = (state_q == ST_SHIFT);
  // Ready while the buffer holds at most its last bit, so the next word is
  // taken as that bit is presented and the chain never sees a bubble.
  assign word_ready   = in_shift && (buf_count_q <= BCNT_W'(1)) &&
                        (word_cnt_q < WCNT_W'(NUM_WORDS));
  assign chain_enable = in_shift && (buf_count_q != '0);
  assign chain_data   = buf_q[0];
  assign chain_nreset = nreset_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    buf_d       = buf_q;
    buf_count_d = buf_count_q;
    bits_after  = bit_cnt_q + BIT_W'(chain_enable);
    remaining   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLEAR;
          clear_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        if (clear_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
          state_d = ST_SHIFT;
        end else begin
          clear_cnt_d = clear_cnt_q + CLR_W'(1);
        end
      end
      ST_SHIFT: begin
        bit_cnt_d = bits_after;
        if (word_valid && word_ready) begin
          // A load may coincide with emitting the old buffer's last bit; the
          // new word replaces the buffer and only the bits still owed to the
          // chain are kept valid (the tail of the last word is dropped).
          buf_d      = word_data;
          word_cnt_d = word_cnt_q + WCNT_W'(1);
          remaining  = BIT_W'(CHAIN_LENGTH) - bits_after;
          if (remaining >= BIT_W'(WORD_WIDTH)) begin
            buf_count_d = BCNT_W'(WORD_WIDTH);
          end else begin
            buf_count_d = BCNT_W'(remaining);
          end
        end else if (chain_enable) begin
          buf_d       = buf_q >> 1;
          buf_count_d = buf_count_q - BCNT_W'(1);
        end
        if (bits_after == BIT_W'(CHAIN_LENGTH)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end

    // The buffer only carries data while shifting; this also empties it on abort.
    if (state_d != ST_SHIFT) begin
      buf_d       = '0;
      buf_count_d = '0;
    end

    nreset_d = (state_d != ST_CLEAR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clear_cnt_q <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      buf_q       <= '0;
      buf_count_q <= '0;
      nreset_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      buf_q       <= buf_d;
      buf_count_q <= buf_count_d;
      nreset_q    <= nreset_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader
//
// Self-checking bench for config_loader. A monitor samples the DUT on the
// falling edge, keeps a model of the daisy-chained tiles and records event
// cycles; each test task drives a load and compares against expectations
// derived from the bit-placement and timing rules of the loader.
module tb_config_loader;

  localparam int WW  = 8;
  localparam int CL  = 146;
  localparam int NW  = 19;
  localparam int CC  = 4;
  localparam int CL2 = 16;

  logic          clock = 1'b0;
  logic          reset, start, abort, word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready, chain_data, chain_enable, chain_nreset, busy, done;

  logic          s_start, s_abort, s_word_valid;
  logic [WW-1:0] s_word_data;
  logic          s_word_ready, s_chain_data, s_chain_enable, s_chain_nreset, s_busy, s_done;

  always #5 clock = ~clock;

  config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .CLEAR_CYCLES(CC)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .chain_data(chain_data), .chain_enable(chain_enable),
    .chain_nreset(chain_nreset), .busy(busy), .done(done)
  );

  config_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL2), .CLEAR_CYCLES(CC)) dut2 (
    .clock(clock), .reset(reset), .start(s_start), .abort(s_abort),
    .word_data(s_word_data), .word_valid(s_word_valid), .word_ready(s_word_ready),
    .chain_data(s_chain_data), .chain_enable(s_chain_enable),
    .chain_nreset(s_chain_nreset), .busy(s_busy), .done(s_done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Words the host intends to load, in order.
  logic [WW-1:0] sent[$];

  // Monitor state
  int        cyc = 0;
  bit        mon_clr = 1'b0;
  int        st_cyc, nr_low, nr_first, ready_first, ready_in_clear;
  int        en_count, en_first, en_last, done_count, done_cyc, busy_fall, acc_count;
  bit        prev_busy;
  logic [CL-1:0] chain;
  bit        emitted[$];

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (mon_clr) begin
        st_cyc = -1; nr_low = 0; nr_first = -1; ready_first = -1; ready_in_clear = 0;
        en_count = 0; en_first = -1; en_last = -1; done_count = 0; done_cyc = -1;
        busy_fall = -1; acc_count = 0; chain = '0; emitted.delete(); prev_busy = busy;
      end else begin
        if (start && !busy && st_cyc < 0) st_cyc = cyc;
        if (!chain_nreset && !reset) begin
          nr_low++;
          if (nr_first < 0) nr_first = cyc;
          if (word_ready) ready_in_clear++;
          chain = '0;
        end
        if (word_ready && ready_first < 0) ready_first = cyc;
        if (word_valid && word_ready) acc_count++;
        if (chain_enable) begin
          en_count++;
          if (en_first < 0) en_first = cyc;
          en_last = cyc;
          emitted.push_back(chain_data);
          // The serial input enters tile position 0 and every enabled edge
          // moves the chain one position further away.
          chain = {chain[CL-2:0], chain_data};
        end
        if (done) begin
          done_count++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc;
        prev_busy = busy;
      end
    end
  end

  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge clock);
    #1 mon_clr = 1'b0;
  endtask

  // Bit k of word w lands at chain position CL-1-(w*WW+k).
  function automatic logic [CL-1:0] exp_chain();
    logic [CL-1:0] e;
    e = '0;
    for (int i = 0; i < CL; i++) e[CL-1-i] = sent[i/WW][i%WW];
    return e;
  endfunction

  task automatic fill_sent(input bit fixed_a5);
    sent.delete();
    for (int w = 0; w < NW; w++) sent.push_back(fixed_a5 ? 8'hA5 : 8'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    vectors++; if (chain_nreset !== 1'b0) begin miscompares++; $display("FAIL rst_nreset: got %b want 0", chain_nreset); end
    vectors++; if (chain_enable !== 1'b0) begin miscompares++; $display("FAIL rst_enable: got %b want 0", chain_enable); end
    vectors++; if (chain_data !== 1'b0) begin miscompares++; $display("FAIL rst_data: got %b want 0", chain_data); end
    vectors++; if (word_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", word_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    @(posedge clock); #1 reset = 1'b0;
    vectors++; if (chain_nreset !== 1'b0) begin miscompares++; $display("FAIL rst_nreset_hold: got %b want 0", chain_nreset); end
    @(posedge clock); #1;
    vectors++; if (chain_nreset !== 1'b1) begin miscompares++; $display("FAIL rst_nreset_rise: got %b want 1", chain_nreset); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  // One complete load. stall: host withholds valid for 8..11 cycles after every
  // other word. busy_start: pulse start once mid-load, which must be ignored.
  task automatic run_load(input string tag, input bit stall, input bit busy_start, input bit fixed_a5);
    int idx = 0;
    int stall_left = 0;
    int k = 0;
    int bs_at;
    int bad_bits = 0;
    int s;
    bit acc, fin, finished = 0;
    logic [CL-1:0] e;
    bs_at = int'($urandom_range(20, 120));
    fill_sent(fixed_a5);
    mon_reset();
    @(posedge clock); #1;
    start = 1'b1; word_valid = 1'b1; word_data = sent[0];
    while (!finished && k < 600) begin
      @(negedge clock);
      acc = word_valid && word_ready;
      fin = done;
      @(posedge clock); #1;
      start = 1'b0;
      k++;
      if (busy_start && k == bs_at) start = 1'b1;
      if (acc) begin
        idx++;
        if (stall && (idx % 2 == 1)) stall_left = int'($urandom_range(8, 11));
      end
      if (stall_left > 0) begin
        word_valid = 1'b0;
        stall_left--;
      end else begin
        // Valid stays high past the last word; that extra word must never be taken.
        word_valid = 1'b1;
        word_data  = (idx < NW) ? sent[idx] : 8'($urandom);
      end
      if (fin) finished = 1;
    end
    @(negedge clock); @(negedge clock);
    word_valid = 1'b0;
    start = 1'b0;
    s = st_cyc;
    e = exp_chain();
    for (int i = 0; i < CL; i++) begin
      if (i >= emitted.size()) bad_bits++;
      else if (emitted[i] !== sent[i/WW][i%WW]) bad_bits++;
    end
    vectors++; if (!finished) begin miscompares++; $display("FAIL %s timeout: done not seen within %0d cycles", tag, k); end
    vectors++; if (nr_low !== CC) begin miscompares++; $display("FAIL %s clear_len: got %0d want %0d", tag, nr_low, CC); end
    vectors++; if (nr_first !== s + 1) begin miscompares++; $display("FAIL %s clear_start: got %0d want %0d", tag, nr_first, s + 1); end
    vectors++; if (ready_in_clear !== 0) begin miscompares++; $display("FAIL %s ready_in_clear: got %0d want 0", tag, ready_in_clear); end
    vectors++; if (ready_first !== s + CC + 1) begin miscompares++; $display("FAIL %s first_ready: got %0d want %0d", tag, ready_first, s + CC + 1); end
    vectors++; if (en_first !== s + CC + 2) begin miscompares++; $display("FAIL %s first_enable: got %0d want %0d", tag, en_first, s + CC + 2); end
    vectors++; if (en_count !== CL) begin miscompares++; $display("FAIL %s enable_count: got %0d want %0d", tag, en_count, CL); end
    if (stall) begin
      vectors++; if (!(en_last - en_first + 1 > en_count)) begin miscompares++; $display("FAIL %s bubbles: span %0d want more than %0d", tag, en_last - en_first + 1, en_count); end
    end else begin
      vectors++; if (en_last !== s + CC + 1 + CL) begin miscompares++; $display("FAIL %s last_enable: got %0d want %0d", tag, en_last, s + CC + 1 + CL); end
    end
    vectors++; if (done_cyc !== en_last + 1) begin miscompares++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc, en_last + 1); end
    vectors++; if (done_count !== 1) begin miscompares++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_count); end
    vectors++; if (busy_fall !== done_cyc + 1) begin miscompares++; $display("FAIL %s busy_fall: got %0d want %0d", tag, busy_fall, done_cyc + 1); end
    vectors++; if (acc_count !== NW) begin miscompares++; $display("FAIL %s words_accepted: got %0d want %0d", tag, acc_count, NW); end
    vectors++; if (bad_bits !== 0) begin miscompares++; $display("FAIL %s bit_stream: got %0d wrong bits want 0", tag, bad_bits); end
    vectors++; if (chain !== e) begin miscompares++; $display("FAIL %s chain_contents: got %h want %h", tag, chain, e); end
  endtask

  task automatic test_abort();
    int idx = 0;
    int k = 0;
    bit acc, hit = 0;
    fill_sent(0);
    mon_reset();
    @(posedge clock); #1;
    start = 1'b1; word_valid = 1'b1; word_data = sent[0];
    while (!hit && k < 400) begin
      @(negedge clock);
      acc = word_valid && word_ready;
      @(posedge clock); #1;
      start = 1'b0;
      k++;
      if (acc && idx < NW - 1) idx++;
      word_data = sent[idx];
      if (en_count >= 70) begin
        abort = 1'b1;
        hit = 1;
      end
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL abort_reach: bit 70 not reached in %0d cycles", k); end
    @(posedge clock); #1;
    abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    vectors++; if (word_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready: got %b want 0", word_ready); end
    vectors++; if (chain_enable !== 1'b0) begin miscompares++; $display("FAIL abort_enable: got %b want 0", chain_enable); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b want 0", done); end
    repeat (10) @(posedge clock);
    #1;
    vectors++; if (done_count !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", done_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_stays_idle: got %b want 0", busy); end
    word_valid = 1'b0;
    run_load("after_abort", 0, 0, 0);
  endtask

  task automatic test_reset_midload();
    int idx = 0;
    int k = 0;
    bit acc, hit = 0;
    fill_sent(0);
    mon_reset();
    @(posedge clock); #1;
    start = 1'b1; word_valid = 1'b1; word_data = sent[0];
    while (!hit && k < 400) begin
      @(negedge clock);
      acc = word_valid && word_ready;
      @(posedge clock); #1;
      start = 1'b0;
      k++;
      if (acc && idx < NW - 1) idx++;
      word_data = sent[idx];
      if (en_count >= 40) hit = 1;
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL areset_reach: bit 40 not reached in %0d cycles", k); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (chain_nreset !== 1'b0) begin miscompares++; $display("FAIL areset_nreset: got %b want 0", chain_nreset); end
    vectors++; if (chain_enable !== 1'b0) begin miscompares++; $display("FAIL areset_enable: got %b want 0", chain_enable); end
    vectors++; if (chain_data !== 1'b0) begin miscompares++; $display("FAIL areset_data: got %b want 0", chain_data); end
    vectors++; if (word_ready !== 1'b0) begin miscompares++; $display("FAIL areset_ready: got %b want 0", word_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL areset_done: got %b want 0", done); end
    word_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    vectors++; if (chain_nreset !== 1'b0) begin miscompares++; $display("FAIL areset_release: got %b want 0", chain_nreset); end
    @(posedge clock); #1;
    vectors++; if (chain_nreset !== 1'b1) begin miscompares++; $display("FAIL areset_rise: got %b want 1", chain_nreset); end
  endtask

  task automatic test_short_chain();
    logic [WW-1:0] w2[3];
    logic [CL2-1:0] got, e;
    int acc = 0;
    int en = 0;
    int dn = 0;
    int last_en = -1;
    int done_k = -1;
    bit a;
    for (int w = 0; w < 3; w++) w2[w] = 8'($urandom);
    e = '0;
    for (int i = 0; i < CL2; i++) e[CL2-1-i] = w2[i/WW][i%WW];
    got = '0;
    @(posedge clock); #1;
    s_start = 1'b1; s_word_valid = 1'b1; s_word_data = w2[0];
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      a = s_word_valid && s_word_ready;
      if (s_chain_enable) begin
        got = {got[CL2-2:0], s_chain_data};
        en++;
        last_en = k;
      end
      if (s_done) begin
        dn++;
        done_k = k;
      end
      if (a) acc++;
      @(posedge clock); #1;
      s_start = 1'b0;
      s_word_data = w2[(acc < 3) ? acc : 2];
    end
    s_word_valid = 1'b0;
    vectors++; if (acc !== 2) begin miscompares++; $display("FAIL short_words: got %0d want 2", acc); end
    vectors++; if (en !== CL2) begin miscompares++; $display("FAIL short_enables: got %0d want %0d", en, CL2); end
    vectors++; if (dn !== 1) begin miscompares++; $display("FAIL short_done_pulses: got %0d want 1", dn); end
    vectors++; if (done_k !== last_en + 1) begin miscompares++; $display("FAIL short_done_cycle: got %0d want %0d", done_k, last_en + 1); end
    vectors++; if (got !== e) begin miscompares++; $display("FAIL short_chain: got %h want %h", got, e); end
    vectors++; if (s_busy !== 1'b0) begin miscompares++; $display("FAIL short_idle: got %b want 0", s_busy); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
    s_start = 1'b0; s_abort = 1'b0; s_word_valid = 1'b0; s_word_data = '0;
    test_reset();
    run_load("full_a5", 0, 0, 1);
    run_load("stall", 1, 0, 0);
    run_load("busy_start", 0, 1, 0);
    test_abort();
    test_reset_midload();
    test_short_chain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
